budget_arbiter: RTL and testbench
=================================

BUDGET_ARBITER -- requirements
Module: budget_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_QUEUES, default 4, number of requesting queues (power of two, >=2).
REQ-002 SHALL have parameter REGISTER_SIZE, default 32, width of budget/period/counter registers.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port empty  input  NUMBER_OF_QUEUES  per-queue empty flag.
REQ-006 SHALL have port budgets  input  NUMBER_OF_QUEUES x REGISTER_SIZE  grants allowed per queue per period.
REQ-007 SHALL have port period  input  REGISTER_SIZE  regulation period in cycles; 0 disables regulation.
REQ-008 SHALL have port consumed  input  1  serializer accepted the granted packet (pulse).
REQ-009 SHALL have port id  output  clog2(NUMBER_OF_QUEUES)  index of granted queue for the selector.
REQ-010 SHALL have port enable  output  1  grant valid to serializer.
REQ-011 SHALL have port hasBeenConsumed  output  NUMBER_OF_QUEUES  one-hot pop pulse to queues.
REQ-012 SHALL have port depleted  output  NUMBER_OF_QUEUES  remaining budget of queue is zero (regulation active).
REQ-013 SHALL have port period_start  output  1  one-cycle pulse on budget replenish.

Function
REQ-014 SHALL implement states IDLE, GRANT, UPDATE.
REQ-015 SHALL define eligible[i] = !empty[i] && (period==0 || remaining[i]!=0).
REQ-016 IDLE: if any eligible, SHALL pick first eligible index searching ptr, ptr+1, ... mod N, register it to id, go GRANT; else stay IDLE.
REQ-017 GRANT: enable SHALL be 1; id SHALL hold stable; on consumed go UPDATE; grant SHALL NOT be withdrawn if empty or budget changes.
REQ-018 UPDATE (one cycle): hasBeenConsumed[id] SHALL be 1 (all else 0); remaining[id] SHALL decrement, saturating at 0, unless period==0; ptr SHALL become (id+1) mod N; next state IDLE.
REQ-019 Latency: eligible in IDLE at edge n -> enable=1 from cycle n+1; consumed at edge m -> hasBeenConsumed pulse in cycle m+1; earliest next enable cycle m+3.
REQ-020 enable and hasBeenConsumed SHALL never be high in the same cycle.
REQ-021 Period counter SHALL count 0..period-1 and wrap; on the wrap cycle SHALL load remaining[i]=budgets[i] for all i and pulse period_start.
REQ-022 Period change SHALL take effect when counter next reaches the new limit; if counter >= new period, SHALL wrap on next cycle.
REQ-023 period==0: counter SHALL hold 0, period_start SHALL stay 0, depleted SHALL be all 0, remaining SHALL NOT change.
REQ-024 Replenish coincident with UPDATE: remaining[id] SHALL become budgets[id]-1 (saturating at 0); other queues load budgets[i].
REQ-025 budgets[i]==0: queue i SHALL never be granted while regulation active.
REQ-026 budgets changes mid-period SHALL take effect only at next replenish.
REQ-027 depleted[i] SHALL equal (period!=0 && remaining[i]==0), registered-state derived, no input combinational path.
REQ-028 consumed outside GRANT SHALL be ignored.

Reset
REQ-029 On reset low: state IDLE, ptr 0, id 0, enable 0, hasBeenConsumed 0, period_start 0, counter 0, remaining[i] 0, depleted derived.
REQ-030 First period_start SHALL occur period cycles after reset release, loading budgets; before it no queue is eligible unless period==0.
REQ-031 Reset asserted during GRANT or UPDATE SHALL drop enable and hasBeenConsumed immediately (asynchronously); no pop SHALL be issued.

Structure
REQ-032 State enum (IDLE/GRANT/UPDATE) and default parameter constants SHALL live in shared package memoredf_pkg.
REQ-033 Round-robin find-first SHALL be a combinational sub-module rr_priority_picker (inputs eligible, ptr; outputs found, index).
REQ-034 No other sub-modules; all registers in budget_arbiter.

Verification
REQ-035 period=0, empty=4'b0000, consumed one cycle after each enable -> ids 0,1,2,3,0 in order; one hasBeenConsumed pulse per grant.
REQ-036 period=100, budgets={1,1,1,2} (q3..q0), all non-empty -> in first period after replenish grants q0,q1,q2,q3,q0; then depleted=4'b1111 until next period_start.
REQ-037 Replenish same cycle as UPDATE for q1, budgets[1]=3 -> remaining[1]=2 after the cycle.
REQ-038 In GRANT of q2, set empty[2]=1 -> enable stays 1, id=2 until consumed; then hasBeenConsumed=4'b0100.
REQ-039 Reset low during GRANT -> enable=0 same cycle; after release no pop, ptr=0, first grant after first period_start.
REQ-040 budgets[0]=0, period=50, only q0 non-empty -> enable never asserts for 500 cycles; period_start every 50 cycles.

Source files
------------

// File: rtl/memoredf_pkg.sv
// Shared FSM states and default sizing for the budget arbiter.
// No logic or latency of its own; no flow control.
package memoredf_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
   localparam int DEFAULT_REGISTER_SIZE    = 32;
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin find-first over eligible queues, starting the search at ptr.
// Purely combinational (0 cycles); no flow control.
module rr_priority_picker
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES
) (
   input  logic [NUMBER_OF_QUEUES-1:0]         eligible,
   input  logic [$clog2(NUMBER_OF_QUEUES)-1:0] ptr,
   output logic                                found,
   output logic [$clog2(NUMBER_OF_QUEUES)-1:0] index
);
   localparam int IW = $clog2(NUMBER_OF_QUEUES);

   logic [IW-1:0] cand;

   // Walk from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = '0;
      for (int k = NUMBER_OF_QUEUES - 1; k >= 0; k--) begin
         cand = ptr + IW'(k);
         if (eligible[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end
endmodule

// File: rtl/budget_arbiter.sv
// Round-robin queue arbiter with per-queue grant budgets replenished every period cycles.
// Grant 1 cycle after eligibility, pop pulse 1 cycle after consumed; grant held until consumed.
module budget_arbiter
   import memoredf_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
   parameter int REGISTER_SIZE    = DEFAULT_REGISTER_SIZE
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [NUMBER_OF_QUEUES-1:0]               empty,
   input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0] budgets,
   input  logic [REGISTER_SIZE-1:0]                  period,
   input  logic                                      consumed,
   output logic [$clog2(NUMBER_OF_QUEUES)-1:0]       id,
   output logic                                      enable,
   output logic [NUMBER_OF_QUEUES-1:0]               hasBeenConsumed,
   output logic [NUMBER_OF_QUEUES-1:0]               depleted,
   output logic                                      period_start
);
   localparam int N  = NUMBER_OF_QUEUES;
   localparam int R  = REGISTER_SIZE;
   localparam int IW = $clog2(N);

   state_t         state;
   logic [IW-1:0]  ptr;
   logic [R-1:0]   counter;
   logic [R-1:0]   remaining [N];
   logic           regulating;
   logic [N-1:0]   eligible;
   logic           found;
   logic [IW-1:0]  pick;
   logic           wrap;

   function automatic logic [R-1:0] sat_dec(input logic [R-1:0] v);
      return (v == '0) ? '0 : v - R'(1);
   endfunction

   // >= rather than == so a shrunk period wraps on the very next cycle.
   assign wrap = (period != '0) && (counter >= period - R'(1));

   always_comb begin
      eligible = '0;
      depleted = '0;
      for (int i = 0; i < N; i++) begin
         eligible[i] = !empty[i] && ((period == '0) || (remaining[i] != '0));
         depleted[i] = regulating && (remaining[i] == '0);
      end
   end

   rr_priority_picker #(.NUMBER_OF_QUEUES(N)) u_picker (
      .eligible (eligible),
      .ptr      (ptr),
      .found    (found),
      .index    (pick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter      <= '0;
         period_start <= 1'b0;
         regulating   <= 1'b0;
      end else begin
         regulating <= (period != '0);
         if (period == '0) begin
            counter      <= '0;
            period_start <= 1'b0;
         end else if (wrap) begin
            counter      <= '0;
            period_start <= 1'b1;
         end else begin
            counter      <= counter + R'(1);
            period_start <= 1'b0;
         end
      end
   end

   // A replenish landing on the UPDATE cycle still charges the granted queue.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) remaining[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (wrap) begin
               if (state == UPDATE && id == IW'(i))
                  remaining[i] <= sat_dec(budgets[i*R +: R]);
               else
                  remaining[i] <= budgets[i*R +: R];
            end else if (state == UPDATE && period != '0 && id == IW'(i)) begin
               remaining[i] <= sat_dec(remaining[i]);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ptr             <= '0;
         id              <= '0;
         enable          <= 1'b0;
         hasBeenConsumed <= '0;
      end else begin
         case (state)
            IDLE: begin
               hasBeenConsumed <= '0;
               if (found) begin
                  id     <= pick;
                  enable <= 1'b1;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (consumed) begin
                  enable          <= 1'b0;
                  hasBeenConsumed <= N'(1) << id;
                  state           <= UPDATE;
               end
            end
            UPDATE: begin
               hasBeenConsumed <= '0;
               ptr             <= id + IW'(1);
               state           <= IDLE;
            end
            default: begin
               enable          <= 1'b0;
               hasBeenConsumed <= '0;
               state           <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_budget_arbiter.sv
// Directed bench for budget_arbiter: grants, budgets, replenish timing and reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_budget_arbiter;
   localparam int N = 4;
   localparam int R = 32;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     empty = '1;
   logic [N*R-1:0]   budgets = '0;
   logic [R-1:0]     period = '0;
   logic             consumed = 1'b0;
   logic [1:0]       id;
   logic             enable;
   logic [N-1:0]     hasBeenConsumed;
   logic [N-1:0]     depleted;
   logic             period_start;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   budget_arbiter #(.NUMBER_OF_QUEUES(N), .REGISTER_SIZE(R)) dut (
      .clock           (clock),
      .reset           (reset),
      .empty           (empty),
      .budgets         (budgets),
      .period          (period),
      .consumed        (consumed),
      .id              (id),
      .enable          (enable),
      .hasBeenConsumed (hasBeenConsumed),
      .depleted        (depleted),
      .period_start    (period_start)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      consumed = 1'b0;
      tick();
      tick();
      check("rst_enable", {31'd0, enable}, 32'd0);
      check("rst_pop", {28'd0, hasBeenConsumed}, 32'd0);
      check("rst_id_ps", {29'd0, id, period_start}, 32'd0);
      check("rst_depleted", {28'd0, depleted}, 32'd0);
      reset = 1'b1;
      cyc   = 0;
   endtask

   // Called on a cycle where the grant is expected; returns on the idle cycle after the pop.
   task automatic grant_cycle(input string t, input int exp_id);
      logic [N-1:0] oh;
      oh = 4'b0001 << exp_id;
      check({t, "_en"}, {31'd0, enable}, 32'd1);
      check({t, "_id"}, {30'd0, id}, exp_id);
      consumed = 1'b1;
      tick();
      consumed = 1'b0;
      check({t, "_pop"}, {28'd0, hasBeenConsumed}, {28'd0, oh});
      check({t, "_en_off"}, {31'd0, enable}, 32'd0);
      tick();
      check({t, "_gap"}, {27'd0, enable, hasBeenConsumed}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seen, bad, early, cnt_ps, cnt_en;
      logic [N-1:0] dep1;

      // Unregulated round robin
      period  = '0;
      empty   = 4'b0000;
      budgets = {32'd1, 32'd1, 32'd1, 32'd1};
      do_reset();
      tick();
      for (int g = 0; g < 5; g++) begin
         grant_cycle("t1", g % 4);
         check("t1_dep", {28'd0, depleted}, 32'd0);
         tick();
      end

      // Budgets {1,1,1,2}, period 100
      period  = 32'd100;
      budgets = {32'd1, 32'd1, 32'd1, 32'd2};
      empty   = 4'b0000;
      do_reset();
      seen = 0; early = 0; dep1 = '0;
      for (int k = 0; k < 200 && seen == 0; k++) begin
         tick();
         if (cyc == 1) dep1 = depleted;
         if (period_start) seen = 1;
         else if (enable) early++;
      end
      check("t2_ps_seen", seen, 1);
      check("t2_ps_cycle", cyc, 100);
      check("t2_no_early", early, 0);
      check("t2_dep_before", {28'd0, dep1}, 32'hF);
      for (int g = 0; g < 5; g++) begin
         tick();
         grant_cycle("t2", g % 4);
      end
      check("t2_dep_all", {28'd0, depleted}, 32'hF);
      seen = 0; bad = 0;
      for (int k = 0; k < 150 && seen == 0; k++) begin
         tick();
         if (period_start) seen = 1;
         else if (enable || depleted != 4'hF) bad++;
      end
      check("t2_ps2_seen", seen, 1);
      check("t2_ps2_cycle", cyc, 200);
      check("t2_hold_depleted", bad, 0);
      check("t2_dep_refill", {28'd0, depleted}, 32'd0);
      tick();
      grant_cycle("t2_next", 1);

      // Replenish coincident with UPDATE of q1
      period  = 32'd40;
      budgets = {32'd3, 32'd3, 32'd3, 32'd3};
      empty   = 4'b1101;
      do_reset();
      while (cyc < 40) tick();
      check("t3_ps40", {31'd0, period_start}, 32'd1);
      bad = 0;
      while (cyc < 78) begin
         tick();
         if (!enable || id != 2'd1) bad++;
      end
      check("t3_grant_held", bad, 0);
      consumed = 1'b1;
      tick();
      consumed = 1'b0;
      check("t3_pop", {28'd0, hasBeenConsumed}, 32'h2);
      tick();
      check("t3_ps80", {31'd0, period_start}, 32'd1);
      check("t3_dep80", {28'd0, depleted}, 32'd0);
      tick();
      grant_cycle("t3a", 1);
      check("t3_dep_one_left", {28'd0, depleted}, 32'd0);
      tick();
      grant_cycle("t3b", 1);
      check("t3_dep_q1", {28'd0, depleted}, 32'h2);
      tick();
      check("t3_no_grant", {31'd0, enable}, 32'd0);

      // Empty rises during grant; consumed outside GRANT is ignored
      period = '0;
      empty  = 4'b1011;
      do_reset();
      tick();
      empty = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         check("t4_hold", {29'd0, enable, id}, {29'd0, 1'b1, 2'd2});
         tick();
      end
      consumed = 1'b1;
      tick();
      consumed = 1'b0;
      check("t4_pop", {28'd0, hasBeenConsumed}, 32'h4);
      tick();
      consumed = 1'b1;
      tick();
      consumed = 1'b0;
      check("t4_stray_consumed", {27'd0, enable, hasBeenConsumed}, 32'd0);
      tick();
      check("t4_stray_after", {27'd0, enable, hasBeenConsumed}, 32'd0);

      // Reset during GRANT
      period = '0;
      empty  = 4'b0000;
      do_reset();
      tick();
      grant_cycle("t5", 0);
      tick();
      period = 32'd20;
      tick();
      check("t5_hold", {29'd0, enable, id}, {29'd0, 1'b1, 2'd1});
      #2 reset = 1'b0;
      consumed = 1'b1;
      #1 check("t5_async_drop", {27'd0, enable, hasBeenConsumed}, 32'd0);
      tick();
      consumed = 1'b0;
      reset = 1'b1;
      cyc = 0;
      seen = 0; bad = 0;
      for (int k = 0; k < 60 && seen == 0; k++) begin
         tick();
         if (period_start) seen = 1;
         else if (enable || hasBeenConsumed != '0) bad++;
      end
      check("t5_ps_cycle", cyc, 20);
      check("t5_quiet", bad, 0);
      tick();
      check("t5_first_grant", {29'd0, enable, id}, {29'd0, 1'b1, 2'd0});

      // Zero budget never granted; period changes
      period  = 32'd50;
      budgets = {32'd5, 32'd5, 32'd5, 32'd0};
      empty   = 4'b1110;
      do_reset();
      cnt_ps = 0; cnt_en = 0; bad = 0;
      for (int k = 0; k < 500; k++) begin
         tick();
         if (enable) cnt_en++;
         if (period_start) begin
            cnt_ps++;
            if (cyc % 50 != 0) bad++;
         end
      end
      check("t6_no_grant", cnt_en, 0);
      check("t6_ps_count", cnt_ps, 10);
      check("t6_ps_spacing", bad, 0);
      repeat (30) tick();
      period = 32'd10;
      tick();
      check("t6_shrink_wrap", {31'd0, period_start}, 32'd1);
      cnt_ps = 0;
      repeat (9) begin
         tick();
         if (period_start) cnt_ps++;
      end
      check("t6_new_period_gap", cnt_ps, 0);
      tick();
      check("t6_new_period_ps", {31'd0, period_start}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
